// File: rtl/cpu65_bus_watch.sv
// Bus watcher for the cpu65 core: traces qualified bus cycles into a FIFO, counts cycles and
// halts on debug-address writes or on a repeated opcode fetch at one PC ("jmp *" trap).
module cpu65_bus_watch #(
    parameter int AW         = 16,
    parameter int DW         = 8,
    parameter int DEPTH      = 16,
    parameter int N_DBG      = 2,
    parameter int TRAP_CNT   = 3,
    parameter int CYC_W      = 32,
    parameter int TRACE_MODE = 1
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      en_i,
    input  logic                                      clr_i,
    input  logic                                      bus_valid_i,
    input  logic [AW-1:0]                             bus_a_i,
    input  logic [DW-1:0]                             bus_d_i,
    input  logic                                      bus_rwn_i,
    input  logic                                      bus_sync_i,
    input  logic [N_DBG*AW-1:0]                       dbg_addr_i,
    input  logic                                      trap_en_i,
    input  logic                                      tr_ready_i,
    output logic                                      tr_valid_o,
    output logic [AW+DW+1:0]                          tr_data_o,
    output logic [$clog2(DEPTH):0]                    tr_count_o,
    output logic                                      tr_overflow_o,
    output logic                                      halt_o,
    output logic [1:0]                                halt_cause_o,
    output logic [((N_DBG > 1) ? $clog2(N_DBG) : 1)-1:0] halt_idx_o,
    output logic [AW-1:0]                             halt_pc_o,
    output logic [DW-1:0]                             halt_data_o,
    output logic [CYC_W-1:0]                          cycles_o
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam int IW   = (N_DBG > 1) ? $clog2(N_DBG) : 1;
    localparam int CW   = $clog2(TRAP_CNT);
    localparam int EW   = AW + DW + 2;

    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);
    localparam logic [CW-1:0]   TRAP_MAX = CW'(TRAP_CNT - 1);
    localparam logic [CW-1:0]   TRAP_ARM = CW'(TRAP_CNT - 2);
    localparam logic [1:0]      TMODE    = 2'(TRACE_MODE);

    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             halt_q, halt_d;
    logic [1:0]       cause_q, cause_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic [DW-1:0]    data_q, data_d;
    logic [CYC_W-1:0] cycles_q, cycles_d;
    logic [CW-1:0]    trap_cnt_q, trap_cnt_d;
    logic [AW-1:0]    last_pc_q, last_pc_d;

    logic             active_s;
    logic             mode_hit_s;
    logic             push_s;
    logic             push_ok_s;
    logic             pop_s;
    logic             full_s;
    logic             dbg_hit_s;
    logic [IW-1:0]    dbg_idx_s;
    logic             dbg_wr_s;
    logic             pc_eq_s;
    logic             trap_s;
    logic [EW-1:0]    entry_s;

    // Qualification, FIFO bookkeeping, halt detection and counters
    always_comb begin
        active_s = bus_valid_i & en_i & ~halt_q & ~clr_i;
        entry_s  = {bus_sync_i, bus_rwn_i, bus_a_i, bus_d_i};

        case (TMODE)
            2'd0:    mode_hit_s = 1'b1;
            2'd1:    mode_hit_s = bus_sync_i | ~bus_rwn_i;
            2'd2:    mode_hit_s = ~bus_rwn_i;
            default: mode_hit_s = 1'b0;
        endcase

        push_s    = active_s & mode_hit_s;
        full_s    = (count_q == CNT_FULL);
        pop_s     = (|count_q) & tr_ready_i & ~clr_i;
        push_ok_s = push_s & (~full_s | pop_s);

        // Descending scan so the lowest matching index is the one that sticks
        dbg_hit_s = 1'b0;
        dbg_idx_s = {IW{1'b0}};
        for (int k = N_DBG - 1; k >= 0; k--) begin
            if (bus_a_i == dbg_addr_i[k*AW +: AW]) begin
                dbg_hit_s = 1'b1;
                dbg_idx_s = IW'(k);
            end else begin
                dbg_hit_s = dbg_hit_s;
            end
        end
        dbg_wr_s = active_s & ~bus_rwn_i & dbg_hit_s;

        pc_eq_s = (bus_a_i == last_pc_q);
        trap_s  = active_s & bus_sync_i & pc_eq_s & (trap_cnt_q == TRAP_ARM) & trap_en_i;

        mem_d = mem_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = entry_s;
        end else begin
            mem_d = mem_q;
        end

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        halt_d     = halt_q;
        cause_d    = cause_q;
        idx_d      = idx_q;
        pc_d       = pc_q;
        data_d     = data_q;
        cycles_d   = cycles_q;
        trap_cnt_d = trap_cnt_q;
        last_pc_d  = last_pc_q;

        if (clr_i) begin
            wr_ptr_d   = {PW{1'b0}};
            rd_ptr_d   = {PW{1'b0}};
            count_d    = {CNTW{1'b0}};
            overflow_d = 1'b0;
            halt_d     = 1'b0;
            cause_d    = 2'd0;
            idx_d      = {IW{1'b0}};
            pc_d       = {AW{1'b0}};
            data_d     = {DW{1'b0}};
            cycles_d   = {CYC_W{1'b0}};
            trap_cnt_d = {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_d = count_q + CNTW'(1);
                2'b01:   count_d = count_q - CNTW'(1);
                default: count_d = count_q;
            endcase
            overflow_d = overflow_q | (push_s & full_s & ~pop_s);

            if (active_s & ~(&cycles_q)) begin
                cycles_d = cycles_q + CYC_W'(1);
            end else begin
                cycles_d = cycles_q;
            end

            if (active_s & bus_sync_i) begin
                last_pc_d = bus_a_i;
                if (!pc_eq_s) begin
                    trap_cnt_d = {CW{1'b0}};
                end else if (trap_cnt_q != TRAP_MAX) begin
                    trap_cnt_d = trap_cnt_q + CW'(1);
                end else begin
                    trap_cnt_d = trap_cnt_q;
                end
            end else begin
                last_pc_d = last_pc_q;
            end

            if (dbg_wr_s) begin
                halt_d  = 1'b1;
                cause_d = 2'd1;
                idx_d   = dbg_idx_s;
                pc_d    = bus_a_i;
                data_d  = bus_d_i;
            end else if (trap_s) begin
                halt_d  = 1'b1;
                cause_d = 2'd2;
                idx_d   = {IW{1'b0}};
                pc_d    = bus_a_i;
                data_d  = {DW{1'b0}};
            end else begin
                halt_d  = halt_q;
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {EW{1'b0}};
            end
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CNTW{1'b0}};
            overflow_q <= 1'b0;
            halt_q     <= 1'b0;
            cause_q    <= 2'd0;
            idx_q      <= {IW{1'b0}};
            pc_q       <= {AW{1'b0}};
            data_q     <= {DW{1'b0}};
            cycles_q   <= {CYC_W{1'b0}};
            trap_cnt_q <= {CW{1'b0}};
            last_pc_q  <= {AW{1'b0}};
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            halt_q     <= halt_d;
            cause_q    <= cause_d;
            idx_q      <= idx_d;
            pc_q       <= pc_d;
            data_q     <= data_d;
            cycles_q   <= cycles_d;
            trap_cnt_q <= trap_cnt_d;
            last_pc_q  <= last_pc_d;
        end
    end

    assign tr_valid_o    = |count_q;
    assign tr_data_o     = mem_q[rd_ptr_q];
    assign tr_count_o    = count_q;
    assign tr_overflow_o = overflow_q;
    assign halt_o        = halt_q;
    assign halt_cause_o  = cause_q;
    assign halt_idx_o    = idx_q;
    assign halt_pc_o     = pc_q;
    assign halt_data_o   = data_q;
    assign cycles_o      = cycles_q;

endmodule

// File: tb/tb_cpu65_bus_watch.sv
// Directed bench for cpu65_bus_watch (TRACE_MODE=0, DEPTH=16, N_DBG=2, TRAP_CNT=3).
module tb_cpu65_bus_watch;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, clr, bus_valid, bus_rwn, bus_sync, trap_en, tr_ready;
    logic [15:0] bus_a;
    logic [7:0]  bus_d;
    logic [31:0] dbg_addr;
    logic        tr_valid, tr_overflow, halt;
    logic [25:0] tr_data;
    logic [4:0]  tr_count;
    logic [1:0]  halt_cause;
    logic [0:0]  halt_idx;
    logic [15:0] halt_pc;
    logic [7:0]  halt_data;
    logic [31:0] cycles;

    int n_checks = 0;
    int n_errors = 0;
    logic [25:0] exp_q[$];

    always #5 clk = ~clk;

    cpu65_bus_watch #(
        .AW(16), .DW(8), .DEPTH(16), .N_DBG(2), .TRAP_CNT(3), .CYC_W(32), .TRACE_MODE(0)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr),
        .bus_valid_i(bus_valid), .bus_a_i(bus_a), .bus_d_i(bus_d),
        .bus_rwn_i(bus_rwn), .bus_sync_i(bus_sync), .dbg_addr_i(dbg_addr),
        .trap_en_i(trap_en), .tr_ready_i(tr_ready),
        .tr_valid_o(tr_valid), .tr_data_o(tr_data), .tr_count_o(tr_count),
        .tr_overflow_o(tr_overflow), .halt_o(halt), .halt_cause_o(halt_cause),
        .halt_idx_o(halt_idx), .halt_pc_o(halt_pc), .halt_data_o(halt_data),
        .cycles_o(cycles)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [7:0] d,
                         input logic rwn, input logic sync);
        bus_valid = v;
        bus_a     = a;
        bus_d     = d;
        bus_rwn   = rwn;
        bus_sync  = sync;
    endtask

    task automatic pulse_clr();
        drive(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    function automatic logic [25:0] ent(input logic s, input logic r,
                                        input logic [15:0] a, input logic [7:0] d);
        return {s, r, a, d};
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, 64'(tr_valid), 64'd0);
        check_eq({tag, "_data"}, 64'(tr_data), 64'd0);
        check_eq({tag, "_count"}, 64'(tr_count), 64'd0);
        check_eq({tag, "_ovf"}, 64'(tr_overflow), 64'd0);
        check_eq({tag, "_halt"}, 64'(halt), 64'd0);
        check_eq({tag, "_cause"}, 64'(halt_cause), 64'd0);
        check_eq({tag, "_idx"}, 64'(halt_idx), 64'd0);
        check_eq({tag, "_pc"}, 64'(halt_pc), 64'd0);
        check_eq({tag, "_hdata"}, 64'(halt_data), 64'd0);
        check_eq({tag, "_cycles"}, 64'(cycles), 64'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; clr = 1'b0; trap_en = 1'b1; tr_ready = 1'b0;
        dbg_addr = {16'hFFFF, 16'hD000};
        drive(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);
        #22;
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // 1: overflow with no consumer, first 16 entries kept in order
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'h1000 + 16'(i), 8'(i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);
        check_eq("t1_count", 64'(tr_count), 64'd16);
        check_eq("t1_ovf", 64'(tr_overflow), 64'd1);
        check_eq("t1_cycles", 64'(cycles), 64'd20);
        tr_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("t1_head%0d", i), 64'(tr_data), 64'(ent(1'b0, 1'b1, 16'h1000 + 16'(i), 8'(i))));
            tick();
        end
        check_eq("t1_empty", 64'(tr_valid), 64'd0);
        check_eq("t1_ovf_sticky", 64'(tr_overflow), 64'd1);
        pulse_clr();
        check_eq("t1_clr_ovf", 64'(tr_overflow), 64'd0);
        check_eq("t1_clr_cycles", 64'(cycles), 64'd0);

        // 2: debug write on cycle 50 halts and freezes the counter
        for (int i = 0; i < 49; i++) begin
            drive(1'b1, 16'h2000, 8'(i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 16'hFFFF, 8'h2A, 1'b0, 1'b0);
        tick();
        check_eq("t2_halt", 64'(halt), 64'd1);
        check_eq("t2_cause", 64'(halt_cause), 64'd1);
        check_eq("t2_idx", 64'(halt_idx), 64'd1);
        check_eq("t2_pc", 64'(halt_pc), 64'hFFFF);
        check_eq("t2_data", 64'(halt_data), 64'h2A);
        check_eq("t2_cycles", 64'(cycles), 64'd50);
        check_eq("t2_traced", 64'(tr_data), 64'(ent(1'b0, 1'b0, 16'hFFFF, 8'h2A)));
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'h2100, 8'h11, 1'b1, 1'b0);
            tick();
        end
        check_eq("t2_frozen", 64'(cycles), 64'd50);
        check_eq("t2_sticky", 64'(halt), 64'd1);
        check_eq("t2_drained", 64'(tr_count), 64'd0);
        pulse_clr();
        check_eq("t2_clr_halt", 64'(halt), 64'd0);

        // 3: jmp * trap; disabled trap; interrupted fetch sequence
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h3469, 8'h4C, 1'b1, 1'b1);
            tick();
            if (i == 1) check_eq("t3_no_early", 64'(halt), 64'd0);
        end
        check_eq("t3_halt", 64'(halt), 64'd1);
        check_eq("t3_cause", 64'(halt_cause), 64'd2);
        check_eq("t3_pc", 64'(halt_pc), 64'h3469);
        check_eq("t3_data", 64'(halt_data), 64'd0);
        pulse_clr();
        trap_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h3469, 8'h4C, 1'b1, 1'b1);
            tick();
        end
        check_eq("t3_dis", 64'(halt), 64'd0);
        trap_en = 1'b1;
        drive(1'b1, 16'h3469, 8'h4C, 1'b1, 1'b1); tick();
        drive(1'b1, 16'h346A, 8'h4C, 1'b1, 1'b1); tick();
        drive(1'b1, 16'h3469, 8'h4C, 1'b1, 1'b1); tick();
        check_eq("t3_broken", 64'(halt), 64'd0);
        pulse_clr();

        // 4: full FIFO, simultaneous push and pop for 10 cycles
        tr_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 16'h4000 + 16'(i), 8'h40 + 8'(i), 1'b1, 1'b0);
            exp_q.push_back(ent(1'b0, 1'b1, 16'h4000 + 16'(i), 8'h40 + 8'(i)));
            tick();
        end
        tr_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            drive(1'b1, 16'h4100 + 16'(j), 8'h50 + 8'(j), 1'b1, 1'b0);
            void'(exp_q.pop_front());
            exp_q.push_back(ent(1'b0, 1'b1, 16'h4100 + 16'(j), 8'h50 + 8'(j)));
            tick();
            check_eq($sformatf("t4_head%0d", j), 64'(tr_data), 64'(exp_q[0]));
        end
        check_eq("t4_count", 64'(tr_count), 64'd16);
        check_eq("t4_ovf", 64'(tr_overflow), 64'd0);
        drive(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("t4_drain%0d", i), 64'(tr_data), 64'(exp_q.pop_front()));
            tick();
        end
        check_eq("t4_empty", 64'(tr_valid), 64'd0);

        // 5: clear beats a simultaneous debug write
        tr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h5000, 8'h01, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 16'hFFFF, 8'h77, 1'b0, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        drive(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);
        check_eq("t5_halt", 64'(halt), 64'd0);
        check_eq("t5_count", 64'(tr_count), 64'd0);
        check_eq("t5_cycles", 64'(cycles), 64'd0);
        tick();
        check_eq("t5_halt_late", 64'(halt), 64'd0);

        // 6: lowest index wins, then asynchronous reset between edges
        dbg_addr = {16'hD000, 16'hD000};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h6000, 8'h02, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 16'hD000, 8'h5A, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);
        check_eq("t6_halt", 64'(halt), 64'd1);
        check_eq("t6_idx", 64'(halt_idx), 64'd0);
        check_eq("t6_data", 64'(halt_data), 64'h5A);
        check_eq("t6_count", 64'(tr_count), 64'd4);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("t6_rst");
        #3;
        rst = 1'b0;
        tick();
        check_eq("t6_after", 64'(tr_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
